l2_cache_param: RTL and testbench

Parametrised, write-back, write-allocate set-associative L2 cache with pseudo-LRU replacement and per-byte write enables. It sits between the L1 arbiter (full-line requests) and physical memory, and replaces the fixed 4-way L2. It adds configurable associativity, set count and line width, synchronous reset of the tag state, and partial-line writes.

---
 rtl/l2_cache_param.sv | 190 +++++++++++++++++++
 tb/tb_l2_cache_param.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache_param.sv
// rtl/l2_cache_param.sv - parametrised write-back, write-allocate set-associative L2 cache
// with tree pseudo-LRU replacement and per-byte write enables.
module l2_cache_param #(
   parameter int WAYS      = 4,
   parameter int SETS      = 8,
   parameter int LINE_BITS = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic [31:0]            mem_address,
   input  logic [LINE_BITS-1:0]   mem_wdata,
   input  logic [LINE_BITS/8-1:0] mem_byte_enable,
   output logic [LINE_BITS-1:0]   mem_rdata,
   output logic                   mem_resp,
   output logic                   pmem_read,
   output logic                   pmem_write,
   output logic [31:0]            pmem_address,
   output logic [LINE_BITS-1:0]   pmem_wdata,
   input  logic [LINE_BITS-1:0]   pmem_rdata,
   input  logic                   pmem_resp
);
   localparam int BYTES = LINE_BITS / 8;
   localparam int OFF   = $clog2(BYTES);
   localparam int IDX   = $clog2(SETS);
   localparam int TAG   = 32 - IDX - OFF;
   localparam int WB    = $clog2(WAYS);
   localparam int LA    = 32 - OFF;

   typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

   state_t                    state_q, state_d;
   logic [LA-1:0]             line_addr_q, line_addr_d;
   logic [LINE_BITS-1:0]      wdata_q, wdata_d;
   logic [BYTES-1:0]          be_q, be_d;
   logic                      write_q, write_d;
   logic [WB-1:0]             victim_q, victim_d;
   logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
   logic [SETS-1:0][WAYS-1:0] dirty_q, dirty_d;
   logic [SETS-1:0][WAYS-2:0] plru_q, plru_d;

   logic [LINE_BITS-1:0]      data_arr [SETS][WAYS];
   logic [TAG-1:0]            tag_arr  [SETS][WAYS];

   logic [IDX-1:0]            idx;
   logic [TAG-1:0]            tag;
   logic                      hit, inv_found, arr_we, tag_we;
   logic [WB-1:0]             hit_way, inv_way, plru_way, arr_way;
   logic [LINE_BITS-1:0]      hit_line, arr_line;
   logic                      unused_addr_bits;

   assign idx              = line_addr_q[IDX-1:0];
   assign tag              = line_addr_q[LA-1:IDX];
   assign unused_addr_bits = ^mem_address[OFF-1:0];

   // Lookup: hit way, lowest invalid way, and the way the PLRU tree points at.
   always_comb begin
      int  node;
      logic bsel;
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && valid_q[idx][w] && tag_arr[idx][w] == tag) begin
            hit     = 1'b1;
            hit_way = WB'(w);
         end
         if (!inv_found && !valid_q[idx][w]) begin
            inv_found = 1'b1;
            inv_way   = WB'(w);
         end
      end
      hit_line = data_arr[idx][hit_way];
      plru_way = '0;
      node     = 0;
      for (int l = 0; l < WB; l++) begin
         bsel = 1'b0;
         for (int n = 0; n < WAYS - 1; n++)
            if (n == node) bsel = plru_q[idx][n];
         plru_way[WB-1-l] = bsel;
         node = 2 * node + 1 + int'(bsel);
      end
   end

   always_comb begin
      int  node;
      logic bsel;
      state_d     = state_q;
      line_addr_d = line_addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      write_d     = write_q;
      victim_d    = victim_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      plru_d      = plru_q;
      arr_we      = 1'b0;
      tag_we      = 1'b0;
      arr_way     = hit_way;
      arr_line    = hit_line;
      node        = 0;
      bsel        = 1'b0;
      case (state_q)
         IDLE: if (mem_read || mem_write) begin
            line_addr_d = mem_address[31:OFF];
            wdata_d     = mem_wdata;
            be_d        = mem_byte_enable;
            write_d     = mem_write;
            state_d     = COMPARE;
         end
         COMPARE: if (hit) begin
            if (write_q) begin
               arr_we = 1'b1;
               for (int b = 0; b < BYTES; b++)
                  if (be_q[b]) arr_line[8*b +: 8] = wdata_q[8*b +: 8];
               dirty_d[idx][hit_way] = 1'b1;
            end
            // Each node on the accessed path now points at the other half.
            for (int l = 0; l < WB; l++) begin
               bsel = hit_way[WB-1-l];
               for (int n = 0; n < WAYS - 1; n++)
                  if (n == node) plru_d[idx][n] = ~bsel;
               node = 2 * node + 1 + int'(bsel);
            end
            state_d = IDLE;
         end else begin
            victim_d = inv_found ? inv_way : plru_way;
            state_d  = (valid_q[idx][victim_d] && dirty_q[idx][victim_d]) ? WRITEBACK : FILL;
         end
         WRITEBACK: if (pmem_resp) state_d = FILL;
         FILL: if (pmem_resp) begin
            arr_we                 = 1'b1;
            tag_we                 = 1'b1;
            arr_way                = victim_q;
            arr_line               = pmem_rdata;
            valid_d[idx][victim_q] = 1'b1;
            dirty_d[idx][victim_q] = 1'b0;
            state_d                = COMPARE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_resp     = (state_q == COMPARE) && hit;
      mem_rdata    = (mem_resp && !write_q) ? hit_line : '0;
      pmem_read    = (state_q == FILL);
      pmem_write   = (state_q == WRITEBACK);
      pmem_address = '0;
      pmem_wdata   = '0;
      if (pmem_write) begin
         pmem_address = {tag_arr[idx][victim_q], idx, {OFF{1'b0}}};
         pmem_wdata   = data_arr[idx][victim_q];
      end else if (pmem_read) begin
         pmem_address = {tag, idx, {OFF{1'b0}}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         line_addr_q <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         write_q     <= 1'b0;
         victim_q    <= '0;
         valid_q     <= '0;
         dirty_q     <= '0;
         plru_q      <= '0;
      end else begin
         state_q     <= state_d;
         line_addr_q <= line_addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         write_q     <= write_d;
         victim_q    <= victim_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         plru_q      <= plru_d;
      end
   end

   // Line storage is never cleared; validity alone decides what is cached.
   always_ff @(posedge clk) begin
      if (arr_we) data_arr[idx][arr_way] <= arr_line;
      if (tag_we) tag_arr[idx][arr_way]  <= tag;
   end
endmodule

// File: tb/tb_l2_cache_param.sv
// tb/tb_l2_cache_param.sv - directed bench for l2_cache_param in three
// configurations (4x8, 2x4, 8x2 ways x sets), each DUT with its own stimulus.
module tb_l2_cache_param;
   logic         clk;
   logic         rst             [3];
   logic         mem_read        [3];
   logic         mem_write       [3];
   logic [31:0]  mem_address     [3];
   logic [255:0] mem_wdata       [3];
   logic [31:0]  mem_byte_enable [3];
   logic [255:0] mem_rdata       [3];
   logic         mem_resp        [3];
   logic         pmem_read       [3];
   logic         pmem_write      [3];
   logic [31:0]  pmem_address    [3];
   logic [255:0] pmem_wdata      [3];
   logic [255:0] pmem_rdata      [3];
   logic         pmem_resp       [3];

   int total, bad;

   int           obs_resp_cyc, obs_nops;
   bit           obs_overlap, obs_resp_after;
   logic [255:0] obs_rdata;
   bit           obs_op_wr    [8];
   logic [31:0]  obs_op_addr  [8];
   logic [255:0] obs_op_wdata [8];
   int           obs_op_cyc   [8];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int GW = (g == 0) ? 4 : (g == 1) ? 2 : 8;
      localparam int GS = (g == 0) ? 8 : (g == 1) ? 4 : 2;
      l2_cache_param #(.WAYS(GW), .SETS(GS), .LINE_BITS(256)) u_dut (
         .clk             (clk),
         .rst             (rst[g]),
         .mem_read        (mem_read[g]),
         .mem_write       (mem_write[g]),
         .mem_address     (mem_address[g]),
         .mem_wdata       (mem_wdata[g]),
         .mem_byte_enable (mem_byte_enable[g]),
         .mem_rdata       (mem_rdata[g]),
         .mem_resp        (mem_resp[g]),
         .pmem_read       (pmem_read[g]),
         .pmem_write      (pmem_write[g]),
         .pmem_address    (pmem_address[g]),
         .pmem_wdata      (pmem_wdata[g]),
         .pmem_rdata      (pmem_rdata[g]),
         .pmem_resp       (pmem_resp[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [255:0] fill_line(input logic [31:0] a);
      if (a == 32'h0000_1000) return {32{8'hA5}};
      return {8{a ^ 32'h5A5A_0000}};
   endfunction

   // Issues one request from a negedge; memory answers each pmem op 3 cycles after it starts.
   task automatic req(input logic [1:0] c, input int mode, input logic [31:0] addr,
                      input logic [255:0] wd, input logic [31:0] be);
      int cyc, op_start;
      bit done;
      mem_read[c]        = (mode != 1);
      mem_write[c]       = (mode != 0);
      mem_address[c]     = addr;
      mem_wdata[c]       = wd;
      mem_byte_enable[c] = be;
      obs_nops = 0; obs_overlap = 0; obs_resp_cyc = -1; obs_rdata = '0;
      cyc = 0; op_start = -1; done = 0;
      while (!done && cyc < 200) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         pmem_resp[c] = 1'b0;
         if (pmem_read[c] && pmem_write[c]) obs_overlap = 1;
         if (pmem_read[c] || pmem_write[c]) begin
            if (op_start < 0) begin
               op_start = cyc;
               if (obs_nops < 8) begin
                  obs_op_wr[obs_nops[2:0]]    = pmem_write[c];
                  obs_op_addr[obs_nops[2:0]]  = pmem_address[c];
                  obs_op_wdata[obs_nops[2:0]] = pmem_wdata[c];
                  obs_op_cyc[obs_nops[2:0]]   = cyc;
               end
               obs_nops++;
            end else if (cyc == op_start + 3) begin
               pmem_resp[c]  = 1'b1;
               pmem_rdata[c] = fill_line(pmem_address[c]);
               op_start      = -1;
            end
         end
         if (mem_resp[c]) begin
            done         = 1;
            obs_resp_cyc = cyc;
            obs_rdata    = mem_rdata[c];
            mem_read[c]  = 1'b0;
            mem_write[c] = 1'b0;
         end
      end
      mem_read[c]  = 1'b0;
      mem_write[c] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      obs_resp_after = mem_resp[c];
      pmem_resp[c]   = 1'b0;
   endtask

   task automatic pulse_reset(input logic [1:0] c);
      rst[c] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst[c] = 1'b0;
   endtask

   task automatic test_reset(input logic [1:0] c);
      rst[c] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({mem_resp[c], pmem_read[c], pmem_write[c]} !== 3'b000) begin
         bad++; $display("FAIL reset_ctl cfg=%0d got=%b want=000", c, {mem_resp[c], pmem_read[c], pmem_write[c]});
      end
      total++;
      if (pmem_address[c] !== 32'h0) begin
         bad++; $display("FAIL reset_paddr cfg=%0d got=%h want=0", c, pmem_address[c]);
      end
      total++;
      if (pmem_wdata[c] !== 256'h0 || mem_rdata[c] !== 256'h0) begin
         bad++; $display("FAIL reset_data cfg=%0d got=%h/%h want=0", c, pmem_wdata[c], mem_rdata[c]);
      end
      rst[c] = 1'b0;
   endtask

   task automatic test_read_after_reset(input logic [1:0] c);
      req(c, 0, 32'h0000_1000, '0, '0);
      total++;
      if (obs_nops !== 1 || obs_op_wr[0] !== 1'b0) begin
         bad++; $display("FAIL rar_ops cfg=%0d got=%0d ops want=1 read", c, obs_nops);
      end
      total++;
      if (obs_op_addr[0] !== 32'h0000_1000 || obs_op_cyc[0] !== 2) begin
         bad++; $display("FAIL rar_pread cfg=%0d got=%h@%0d want=00001000@2", c, obs_op_addr[0], obs_op_cyc[0]);
      end
      total++;
      if (obs_resp_cyc !== 6 || obs_rdata !== {32{8'hA5}}) begin
         bad++; $display("FAIL rar_resp cfg=%0d got=%0d/%h want=6/a5..", c, obs_resp_cyc, obs_rdata);
      end
      total++;
      if (obs_overlap !== 1'b0 || obs_resp_after !== 1'b0) begin
         bad++; $display("FAIL rar_proto cfg=%0d got=%b%b want=00", c, obs_overlap, obs_resp_after);
      end
   endtask

   task automatic test_repeat_read(input logic [1:0] c);
      req(c, 0, 32'h0000_1000, '0, '0);
      total++;
      if (obs_nops !== 0 || obs_resp_cyc !== 1) begin
         bad++; $display("FAIL hit_timing cfg=%0d got=%0d ops resp@%0d want=0 ops resp@1", c, obs_nops, obs_resp_cyc);
      end
      total++;
      if (obs_rdata !== {32{8'hA5}}) begin
         bad++; $display("FAIL hit_data cfg=%0d got=%h want=a5..", c, obs_rdata);
      end
   endtask

   task automatic test_partial_write(input logic [1:0] c);
      logic [255:0] exp;
      exp        = {32{8'hA5}};
      exp[31:0]  = 32'hFFFF_FFFF;
      req(c, 2, 32'h0000_1000, {8{32'hFFFF_FFFF}}, 32'h0000_000F);
      total++;
      if (obs_nops !== 0 || obs_resp_cyc !== 1) begin
         bad++; $display("FAIL pw_hit cfg=%0d got=%0d ops resp@%0d want=0 ops resp@1", c, obs_nops, obs_resp_cyc);
      end
      req(c, 0, 32'h0000_1000, '0, '0);
      total++;
      if (obs_rdata !== exp) begin
         bad++; $display("FAIL pw_merge cfg=%0d got=%h want=%h", c, obs_rdata, exp);
      end
   endtask

   task automatic test_back_to_back(input logic [1:0] c);
      logic [5:0] pat;
      mem_read[c]    = 1'b1;
      mem_address[c] = 32'h0000_1000;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         @(negedge clk);
         pat[k] = mem_resp[c];
         if (k == 5) mem_read[c] = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (pat !== 6'b010101) begin
         bad++; $display("FAIL b2b_pattern cfg=%0d got=%b want=010101", c, pat);
      end
   endtask

   task automatic test_eviction(input logic [1:0] c);
      logic [31:0]  s, fin;
      logic [31:0]  seq[$];
      logic [255:0] wd;
      int           w;
      s  = (c == 0) ? 32'h100 : (c == 1) ? 32'h80 : 32'h40;
      w  = (c == 0) ? 4 : (c == 1) ? 2 : 8;
      wd = {8{32'hC0DE_F00D}};
      pulse_reset(c);
      for (int k = 0; k < w; k++) begin
         req(c, 0, 32'(k) * s, '0, '0);
         total++;
         if (obs_nops !== 1 || obs_op_addr[0] !== 32'(k) * s) begin
            bad++; $display("FAIL ev_fill cfg=%0d k=%0d got=%0d/%h want=1/%h", c, k, obs_nops, obs_op_addr[0], 32'(k) * s);
         end
      end
      req(c, 0, 32'h0, '0, '0);
      req(c, 1, s, wd, 32'hFFFF_FFFF);
      total++;
      if (obs_nops !== 0) begin
         bad++; $display("FAIL ev_hits cfg=%0d got=%0d ops want=0", c, obs_nops);
      end
      req(c, 0, 32'(w) * s, '0, '0);
      total++;
      if (obs_nops !== 1 || obs_op_wr[0] !== 1'b0 || obs_op_addr[0] !== 32'(w) * s) begin
         bad++; $display("FAIL ev_clean cfg=%0d got=%0d/%b/%h want=1/0/%h", c, obs_nops, obs_op_wr[0], obs_op_addr[0], 32'(w) * s);
      end
      case (c)
         2'd0:    begin seq.push_back(32'h0); seq.push_back(4 * s); fin = 5 * s; end
         2'd1:    begin seq.push_back(2 * s); fin = 3 * s; end
         default: begin seq.push_back(32'h0); seq.push_back(2 * s); seq.push_back(8 * s); fin = 9 * s; end
      endcase
      foreach (seq[i]) begin
         req(c, 0, seq[i], '0, '0);
         total++;
         if (obs_nops !== 0) begin
            bad++; $display("FAIL ev_rehit cfg=%0d addr=%h got=%0d ops want=0", c, seq[i], obs_nops);
         end
      end
      req(c, 0, fin, '0, '0);
      total++;
      if (obs_nops !== 2 || obs_op_wr[0] !== 1'b1 || obs_op_addr[0] !== s || obs_op_cyc[0] !== 2) begin
         bad++; $display("FAIL ev_wb cfg=%0d got=%0d/%b/%h@%0d want=2/1/%h@2", c, obs_nops, obs_op_wr[0], obs_op_addr[0], obs_op_cyc[0], s);
      end
      total++;
      if (obs_op_wdata[0] !== wd) begin
         bad++; $display("FAIL ev_wbdata cfg=%0d got=%h want=%h", c, obs_op_wdata[0], wd);
      end
      total++;
      if (obs_op_wr[1] !== 1'b0 || obs_op_addr[1] !== fin || obs_op_cyc[1] !== 6) begin
         bad++; $display("FAIL ev_refill cfg=%0d got=%b/%h@%0d want=0/%h@6", c, obs_op_wr[1], obs_op_addr[1], obs_op_cyc[1], fin);
      end
      total++;
      if (obs_resp_cyc !== 10 || obs_rdata !== fill_line(fin) || obs_overlap !== 1'b0) begin
         bad++; $display("FAIL ev_resp cfg=%0d got=%0d/%h want=10/%h", c, obs_resp_cyc, obs_rdata, fill_line(fin));
      end
   endtask

   task automatic test_reset_mid_fill(input logic [1:0] c);
      bit seen;
      logic [31:0] s;
      s = (c == 0) ? 32'h100 : (c == 1) ? 32'h80 : 32'h40;
      pulse_reset(c);
      req(c, 0, 32'h0, '0, '0);
      mem_read[c]    = 1'b1;
      mem_address[c] = s;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(posedge clk);
         @(negedge clk);
         seen = pmem_read[c];
      end
      total++;
      if (!seen) begin
         bad++; $display("FAIL rmf_fill cfg=%0d got=no pmem_read want=pmem_read", c);
      end
      rst[c] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst[c]      = 1'b0;
      mem_read[c] = 1'b0;
      total++;
      if ({pmem_read[c], pmem_write[c], mem_resp[c]} !== 3'b000) begin
         bad++; $display("FAIL rmf_abort cfg=%0d got=%b want=000", c, {pmem_read[c], pmem_write[c], mem_resp[c]});
      end
      req(c, 0, 32'h0, '0, '0);
      total++;
      if (obs_nops !== 1 || obs_resp_cyc !== 6) begin
         bad++; $display("FAIL rmf_remiss cfg=%0d got=%0d ops resp@%0d want=1 op resp@6", c, obs_nops, obs_resp_cyc);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 3; i++) begin
         rst[i]             = 1'b1;
         mem_read[i]        = 1'b0;
         mem_write[i]       = 1'b0;
         mem_address[i]     = '0;
         mem_wdata[i]       = '0;
         mem_byte_enable[i] = '0;
         pmem_rdata[i]      = '0;
         pmem_resp[i]       = 1'b0;
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         test_reset(2'(i));
         test_read_after_reset(2'(i));
         test_repeat_read(2'(i));
         test_partial_write(2'(i));
         test_back_to_back(2'(i));
         test_eviction(2'(i));
         test_reset_mid_fill(2'(i));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
